// File: rtl/sasm_pkg.sv
// Shared definitions for the shift-and-add multiplier operand feeder.
package sasm_pkg;

  localparam int WL_DEF    = 4;
  localparam int DEPTH_DEF = 4;

  // Run time of the multiplier in cycles, derived from the operand width.
  function automatic int mul_cycles_for(input int wl);
    return 2 * wl;
  endfunction

  // Ceiling log2. Returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = 1; x < v; x = x * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Feeder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/sasm_op_fifo.sv
// Synchronous FIFO holding {a,b} operand pairs.
// Handshake: a push happens on an edge where i_push is high, a pop on an
// edge where i_pop is high; the caller never pushes when full or pops when
// empty. o_data always shows the head entry.
module sasm_op_fifo
  import sasm_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [W-1:0]            i_data,
  output logic [W-1:0]            o_data,
  output logic [clog2(DEPTH):0]   o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage array: written on push only, contents are don't-care when empty.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks
  // push/pop, unchanged when both happen on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/sasm_feeder.sv
// Operand feeder for the shift-and-add serial multiplier. Buffers operand
// pairs and issues one per multiplication: a one-cycle load strobe, then the
// operands held stable for the multiplier run time.
// Upstream handshake: a pair is taken on every edge where s_valid && s_ready;
// s_ready depends only on registered occupancy, and the producer holds
// s_valid/s_a/s_b until the pair is taken.
module sasm_feeder
  import sasm_pkg::*;
#(
  parameter int WL         = WL_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int MUL_CYCLES = mul_cycles_for(WL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WL-1:0]          s_a,
  input  logic [WL-1:0]          s_b,
  output logic [WL-1:0]          in1,
  output logic [WL-1:0]          in2,
  output logic                   load,
  output logic                   busy,
  output logic                   done,
  output logic [clog2(DEPTH):0]  count,
  output logic [1:0]             dbg_state
);

  localparam int CW   = clog2(DEPTH) + 1;
  localparam int CNTW = (clog2(MUL_CYCLES + 1) < 1) ? 1 : clog2(MUL_CYCLES + 1);

  feeder_state_t   r_state;
  logic [WL-1:0]   r_in1;
  logic [WL-1:0]   r_in2;
  logic            r_load;
  logic            r_busy;
  logic [CNTW-1:0] r_cnt;

  logic [2*WL-1:0] w_head;
  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_push     = s_valid && !w_full;
  // A pop only ever accompanies entry to LOAD.
  assign w_pop      = !w_empty && ((r_state == IDLE) ||
                                   ((r_state == WAIT) && w_cnt_zero));

  sasm_op_fifo #(
    .W     (2 * WL),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({s_a, s_b}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Issue FSM: pop and latch operands on entry to LOAD, then count out the
  // multiplier run time in WAIT before the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_in1   <= '0;
      r_in2   <= '0;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_in1   <= w_head[2*WL-1:WL];
            r_in2   <= w_head[WL-1:0];
            r_load  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_load  <= 1'b0;
          r_cnt   <= CNTW'(MUL_CYCLES - 1);
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_cnt_zero) begin
            if (w_pop) begin
              r_in1   <= w_head[2*WL-1:WL];
              r_in2   <= w_head[WL-1:0];
              r_load  <= 1'b1;
              r_state <= LOAD;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CNTW'(1);
          end
        end
        default: begin
          r_load  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s_ready   = !w_full;
  assign in1       = r_in1;
  assign in2       = r_in2;
  assign load      = r_load;
  assign busy      = r_busy;
  assign done      = (r_state == WAIT) && w_cnt_zero;
  assign count     = w_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sasm_feeder.sv
// Bench for sasm_feeder: reset checks, a table of single-pair transactions,
// and hand-written sequences for streaming, same-edge push/pop, mid-run reset
// and idle behaviour. A negedge monitor keeps an expected queue of accepted
// pairs and checks every load, operand hold, done timing and occupancy.
module tb_sasm_feeder;

  localparam int WL    = 4;
  localparam int DEPTH = 4;
  localparam int MUL   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [WL-1:0] s_a = '0;
  logic [WL-1:0] s_b = '0;
  logic [WL-1:0] in1;
  logic [WL-1:0] in2;
  logic          load;
  logic          busy;
  logic          done;
  logic [2:0]    count;
  logic [1:0]    dbg_state;

  sasm_feeder #(
    .WL         (WL),
    .DEPTH      (DEPTH),
    .MUL_CYCLES (MUL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_a       (s_a),
    .s_b       (s_b),
    .in1       (in1),
    .in2       (in2),
    .load      (load),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [2*WL-1:0] exp_q[$];
  logic [2*WL-1:0] exp_e;
  int cyc       = 0;
  int done_due  = -1;
  int n_load    = 0;
  int n_done    = 0;
  int full_seen = 0;
  int load_cyc[$];
  logic [WL-1:0] cur_a = '0;
  logic [WL-1:0] cur_b = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (load) begin
      n_load++;
      load_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("load_with_nothing_pushed", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("in1_at_load", 32'(in1), 32'(exp_e[2*WL-1:WL]));
        chk("in2_at_load", 32'(in2), 32'(exp_e[WL-1:0]));
        cur_a = exp_e[2*WL-1:WL];
        cur_b = exp_e[WL-1:0];
      end
      chk("busy_at_load", 32'(busy), 32'd1);
      done_due = cyc + MUL;
    end else if (busy) begin
      chk("in1_hold", 32'(in1), 32'(cur_a));
      chk("in2_hold", 32'(in2), 32'(cur_b));
    end
    if (done) n_done++;
    if (done || (cyc == done_due)) chk("done_timing", 32'(done), 32'(cyc == done_due));
    chk("count_occupancy", 32'(count), 32'(exp_q.size()));
    chk("s_ready_vs_count", 32'(s_ready), 32'(count != 3'(DEPTH)));
    if ((count == 3'(DEPTH)) && !s_ready) full_seen++;
    if (rst) begin
      exp_q.delete();
      done_due = -1;
    end else if (s_valid && s_ready) begin
      exp_q.push_back({s_a, s_b});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call right after a rising edge (+1). Holds the pair until accepted,
  // returns just after the accepting edge.
  task automatic push_one(input logic [WL-1:0] a, input logic [WL-1:0] b);
    bit acc;
    acc = 1'b0;
    s_a = a;
    s_b = b;
    s_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (s_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("push_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!busy && !load && (count == 3'd0)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [WL-1:0] a;
    logic [WL-1:0] b;
    logic [WL-1:0] exp_in1;
    logic [WL-1:0] exp_in2;
    int            lat_load;
    int            lat_done;
  } vec_t;

  vec_t vecs[5];

  // ---------------- main sequence ----------------
  initial begin
    int k;
    bit got;
    int extra_loads;
    int snap_load;
    int snap_done;
    int busy_hits;

    vecs[0] = '{4'hF, 4'hF, 4'hF, 4'hF, 2, 10};
    vecs[1] = '{4'hA, 4'h5, 4'hA, 4'h5, 2, 10};
    vecs[2] = '{4'h5, 4'hA, 4'h5, 4'hA, 2, 10};
    vecs[3] = '{4'h1, 4'hE, 4'h1, 4'hE, 2, 10};
    vecs[4] = '{4'h0, 4'h9, 4'h0, 4'h9, 2, 10};

    // 1. reset for two edges, check state in the first cycle after release
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in1", 32'(in1), 32'd0);
    chk("rst_in2", 32'(in2), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_state_idle", 32'(dbg_state), 32'd0);

    // 6. empty feeder stays idle
    snap_load = n_load;
    busy_hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) busy_hits++;
    end
    chk("idle_no_load", 32'(n_load - snap_load), 32'd0);
    chk("idle_no_busy", 32'(busy_hits), 32'd0);

    // 2. table: single pair into an idle feeder
    for (int i = 0; i < 5; i++) begin
      wait_idle();
      sync();
      push_one(vecs[i].a, vecs[i].b);
      k = 0;
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        k++;
        if (load) begin
          got = 1'b1;
          break;
        end
      end
      chk("tbl_load_latency", got ? 32'(k) : 32'hFFFF_FFFF, 32'(vecs[i].lat_load));
      chk("tbl_in1", 32'(in1), 32'(vecs[i].exp_in1));
      chk("tbl_in2", 32'(in2), 32'(vecs[i].exp_in2));
      extra_loads = 0;
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        k++;
        if (load) extra_loads++;
        if (done) begin
          got = 1'b1;
          break;
        end
      end
      chk("tbl_done_latency", got ? 32'(k) : 32'hFFFF_FFFF, 32'(vecs[i].lat_done));
      chk("tbl_load_one_cycle", 32'(extra_loads), 32'd0);
      @(negedge clk);
      chk("tbl_busy_after_done", 32'(busy), 32'd0);
    end

    // 3. back-to-back stream with backpressure
    wait_idle();
    sync();
    load_cyc.delete();
    snap_done = n_done;
    full_seen = 0;
    push_one(4'hE, 4'h7);
    push_one(4'hB, 4'h5);
    push_one(4'h8, 4'h8);
    push_one(4'h1, 4'h1);
    push_one(4'h3, 4'h2);
    wait_idle();
    chk("stream_load_count", 32'(load_cyc.size()), 32'd5);
    for (int i = 1; i < load_cyc.size(); i++) begin
      chk("stream_load_spacing", 32'(load_cyc[i] - load_cyc[i-1]), 32'(MUL + 1));
    end
    chk("stream_done_count", 32'(n_done - snap_done), 32'd5);
    chk("stream_full_seen", 32'(full_seen != 0), 32'd1);

    // 4. push on the WAIT->LOAD edge with two pairs buffered
    wait_idle();
    sync();
    snap_load = n_load;
    push_one(4'h2, 4'h3);
    push_one(4'h4, 4'h5);
    push_one(4'h6, 4'h7);
    got = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk);
      #1;
      if (done && (count == 3'd2)) begin
        got = 1'b1;
        break;
      end
    end
    chk("same_edge_setup", 32'(got), 32'd1);
    s_a = 4'h9;
    s_b = 4'hA;
    s_valid = 1'b1;
    @(negedge clk);
    chk("same_edge_count_before", 32'(count), 32'd2);
    chk("same_edge_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    chk("same_edge_count_after", 32'(count), 32'd2);
    chk("same_edge_load", 32'(load), 32'd1);
    wait_idle();
    chk("same_edge_load_total", 32'(n_load - snap_load), 32'd4);

    // 5. reset in the middle of WAIT with two pairs buffered
    wait_idle();
    sync();
    push_one(4'hC, 4'hD);
    push_one(4'hE, 4'hF);
    push_one(4'h1, 4'h2);
    repeat (3) @(negedge clk);
    chk("midrst_pre_count", 32'(count), 32'd2);
    chk("midrst_pre_state_wait", 32'(dbg_state), 32'd2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_load", 32'(load), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    snap_load = n_load;
    snap_done = n_done;
    repeat (20) @(negedge clk);
    chk("midrst_no_load", 32'(n_load - snap_load), 32'd0);
    chk("midrst_no_done", 32'(n_done - snap_done), 32'd0);
    sync();
    push_one(4'h4, 4'h4);
    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (load) begin
        got = 1'b1;
        break;
      end
    end
    chk("midrst_new_load", 32'(got), 32'd1);
    chk("midrst_new_in1", 32'(in1), 32'h4);
    chk("midrst_new_in2", 32'(in2), 32'h4);
    wait_idle();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #200000;
    n_vec++;
    n_miss++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
